seq_mag_comparator: RTL
=======================

// Module: seq_mag_comparator
// PURPOSE
//  Parametrised successor to the 4-bit equality comparator. Compares two WIDTH-bit operands
//  MSB-chunk first, CHUNK bits per clock, with early exit at the first differing chunk.
//  Reports eq/lt/gt in unsigned or two's-complement mode over a valid/ready handshake.
//  Used where wide operands must be compared without a full-width single-cycle tree.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of CHUNK
//  CHUNK  4   bits compared per cycle; 1 <= CHUNK < WIDTH
//  NCHUNK = WIDTH/CHUNK (derived, >=2); IW = $clog2(NCHUNK) (derived)
// PORTS
//  clk          in   1      single clock; all state changes on its rising edge
//  rst_n        in   1      synchronous, active-low reset
//  in_valid     in   1      operands/mode valid
//  in_ready     out  1      block can accept an operation
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  signed_mode  in   1      1 = two's complement compare, 0 = unsigned
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer takes result
//  eq           out  1      A == B
//  lt           out  1      A < B
//  gt           out  1      A > B
//  diff_idx     out  IW     index of first differing chunk (0 when eq)
// BEHAVIOUR
//  - States: IDLE, CMP, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - Reset (rst_n=0 at an edge): state->IDLE, eq/lt/gt/diff_idx->0, index->0, operand regs->0.
//    Overrides any in-flight operation and any held result; inputs are ignored while rst_n=0.
//  - IDLE: in_valid=1 at an edge -> capture a, b, signed_mode; index<=NCHUNK-1; ->CMP.
//    In signed mode, the MSB of both captured operands is inverted (offset binary), making
//    the unsigned chunk compare correct.
//  - CMP, one chunk per cycle: compare a_r[idx*CHUNK +: CHUNK] with b_r[same].
//      chunks differ         -> lt/gt from that chunk, eq=0, diff_idx=idx, ->DONE
//      equal and idx==0      -> eq=1, lt=gt=0, diff_idx=0, ->DONE
//      equal and idx>0       -> idx<=idx-1, stay in CMP
//  - Latency: with accept at edge n and k chunks examined (1..NCHUNK), out_valid is high
//    from edge n+k.
//  - DONE: eq/lt/gt/diff_idx are held stable while out_valid=1. out_ready=1 at an edge ->IDLE.
//    Results keep their values in IDLE until the next operation's result is written.
//  - Exactly one of eq/lt/gt is 1 whenever out_valid=1.
//  - in_valid outside IDLE is ignored (no queueing). Minimum spacing between accepts is k+2 cycles.
//  - Inputs a/b/signed_mode need to be stable only in the accept cycle.
// TESTING (WIDTH=16, CHUNK=4)
//  1. a=16'h1234, b=16'h1234, unsigned -> out_valid 4 cycles after accept, eq=1, diff_idx=0.
//  2. a=16'h9000, b=16'h1000, unsigned -> gt=1, diff_idx=3, latency 1;
//     same operands, signed_mode=1 -> lt=1, latency 1.
//  3. a=16'h12A4, b=16'h12A5, unsigned -> lt=1, diff_idx=0, latency 4;
//     a=16'hFFFF, b=16'h0000, signed -> lt=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands ->
//     eq/lt/gt/diff_idx stay stable, in_ready=0, the new op is not taken.
//  5. Reset mid-CMP (case 3, after 2 cycles) -> next edge: IDLE, out_valid=0, outputs 0;
//     after release, case 1 runs correctly.
//  6. Back-to-back with in_valid=1 and out_ready=1 held -> accepts exactly k+2 cycles apart.
//     Random 1000-op signed/unsigned run matches $signed/unsigned reference compare.

Source files
------------

// File: rtl/seq_mag_comparator_if.sv
// Operand/result handshake bundle for seq_mag_comparator.
// The master drives operands and accepts results; the slave is the comparator.
interface seq_mag_comparator_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = $clog2(NCHUNK);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [IW-1:0]    diff_idx;

    modport master (
        output in_valid,
        output a,
        output b,
        output signed_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  eq,
        input  lt,
        input  gt,
        input  diff_idx
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  signed_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output eq,
        output lt,
        output gt,
        output diff_idx
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB chunk first,
// CHUNK bits per clock, and stops at the first chunk that differs.
// Signed compares are turned into unsigned ones by flipping both sign bits at capture.
module seq_mag_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic                clk,
    input logic                rst_n,
    seq_mag_comparator_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = $clog2(NCHUNK);

    if ((CHUNK < 1) || (CHUNK >= WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("seq_mag_comparator: WIDTH must be a multiple of CHUNK and CHUNK < WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic [IW-1:0]    diff_idx_q, diff_idx_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;

    // Select the chunk currently under examination from both captured operands.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Next-state logic: capture in idle, one chunk per cycle in compare, hold in done.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        eq_d       = eq_q;
        lt_d       = lt_q;
        gt_d       = gt_q;
        diff_idx_d = diff_idx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    // Offset-binary: flipping the sign bit orders two's complement values
                    // the same way as unsigned ones.
                    if (bus.signed_mode) begin
                        a_d[WIDTH-1] = ~bus.a[WIDTH-1];
                        b_d[WIDTH-1] = ~bus.b[WIDTH-1];
                    end
                    idx_d   = IW'(NCHUNK - 1);
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (a_chunk != b_chunk) begin
                    eq_d       = 1'b0;
                    lt_d       = (a_chunk < b_chunk);
                    gt_d       = (a_chunk > b_chunk);
                    diff_idx_d = idx_q;
                    state_d    = StDone;
                end else if (idx_q == '0) begin
                    eq_d       = 1'b1;
                    lt_d       = 1'b0;
                    gt_d       = 1'b0;
                    diff_idx_d = '0;
                    state_d    = StDone;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            diff_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            gt_q       <= gt_d;
            diff_idx_q <= diff_idx_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.gt        = gt_q;
    assign bus.diff_idx  = diff_idx_q;

endmodule
